// File: rtl/core_run_sequencer.sv
// Run-control sequencer for the 9-bit core: holds the core in reset while idle,
// releases it on request, gates execution, counts cycles and reports completion.
module core_run_sequencer #(
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             step_mode,
   input  logic             step_pulse,
   input  logic             core_done,
   output logic             core_reset,
   output logic             core_en,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RST_HOLD = 2'd1,
      S_RUN      = 2'd2,
      S_FINISH   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic             timeout_q, timeout_d;
   logic             core_reset_q, core_reset_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             run_en;

   // Core enable is combinational so step_mode/step_pulse/core_done act in the same cycle.
   assign run_en = (state_q == S_RUN) && !core_done && (!step_mode || step_pulse);

   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      cycle_count_d = cycle_count_q;
      timeout_d     = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d       = S_RST_HOLD;
               rst_cnt_d     = '0;
               cycle_count_d = '0;
               timeout_d     = 1'b0;
            end
         end
         S_RST_HOLD: begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
            if (rst_cnt_q == RST_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // core_done takes priority over the watchdog in the same cycle.
            if (core_done) begin
               state_d = S_FINISH;
            end else if (run_en) begin
               cycle_count_d = cycle_count_q + CNT_W'(1);
               if (cycle_count_q == CNT_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            if (!req) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      core_reset_d = (state_d == S_IDLE) || (state_d == S_RST_HOLD);
      busy_d       = (state_d == S_RST_HOLD) || (state_d == S_RUN);
      done_d       = (state_d == S_FINISH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         rst_cnt_q     <= '0;
         cycle_count_q <= '0;
         timeout_q     <= 1'b0;
         core_reset_q  <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         cycle_count_q <= cycle_count_d;
         timeout_q     <= timeout_d;
         core_reset_q  <= core_reset_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign core_reset  = core_reset_q;
   assign core_en     = run_en;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed scenarios plus randomized traffic for core_run_sequencer, checked
// cycle-by-cycle against a behavioural run model.
module tb_core_run_sequencer;

   localparam int unsigned RST_CYCLES = 2;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned TIMEOUT    = 20;

   logic             clk = 1'b0;
   logic             reset, req, step_mode, step_pulse, core_done;
   logic             core_reset, core_en, busy, done, timeout;
   logic [CNT_W-1:0] cycle_count;

   always #5 clk = ~clk;

   core_run_sequencer #(
      .RST_CYCLES (RST_CYCLES),
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .step_mode   (step_mode),
      .step_pulse  (step_pulse),
      .core_done   (core_done),
      .core_reset  (core_reset),
      .core_en     (core_en),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;
   int en_seen = 0;
   bit last_en = 1'b0;

   // Run model: hold cycles left, running flag, finished flag, count, watchdog flag.
   int m_hold  = 0;
   bit m_run   = 1'b0;
   bit m_fin   = 1'b0;
   int m_count = 0;
   bit m_to    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      if (chk_on) begin
         chk("core_reset", 32'(core_reset), 32'(!m_run && !m_fin));
         chk("busy", 32'(busy), 32'(m_hold > 0 || m_run));
         chk("done", 32'(done), 32'(m_fin));
         chk("timeout", 32'(timeout), 32'(m_to));
         chk("cycle_count", 32'(cycle_count), 32'(m_count));
         chk("core_en", 32'(core_en), 32'(m_run && !core_done && (!step_mode || step_pulse)));
      end
      last_en = (core_en === 1'b1);
      if (last_en) en_seen++;
      @(posedge clk);
      if (reset) begin
         m_hold = 0; m_run = 0; m_fin = 0; m_count = 0; m_to = 0;
      end else if (m_fin) begin
         if (!req) m_fin = 0;
      end else if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0) m_run = 1;
      end else if (m_run) begin
         if (core_done) begin
            m_run = 0; m_fin = 1;
         end else if (!step_mode || step_pulse) begin
            m_count++;
            if (m_count == TIMEOUT) begin
               m_to = 1; m_run = 0; m_fin = 1;
            end
         end
      end else if (req) begin
         m_hold = RST_CYCLES; m_count = 0; m_to = 0;
      end
      chk_on = 1'b1;
      #1;
   endtask

   task automatic wait_run(input string tag);
      int g = 0;
      while (!m_run && g < 50) begin cyc(); g++; end
      chk(tag, 32'(g < 50), 32'd1);
   endtask

   // Finish a run by raising core_done once the count reaches n (n<0: never).
   task automatic finish_at(input string tag, input int n);
      int g = 0;
      while (!m_fin && g < 200) begin
         core_done = m_run && (m_count == n);
         cyc(); g++;
      end
      core_done = 1'b0;
      chk(tag, 32'(g < 200), 32'd1);
      cyc();
   endtask

   task automatic release_req();
      req = 1'b0;
      cyc(); cyc();
   endtask

   initial begin
      int k;
      reset = 1'b1; req = 1'b0; step_mode = 1'b0; step_pulse = 1'b0; core_done = 1'b0;
      cyc(); cyc();
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_cycle_count", 32'(cycle_count), 32'd0);
      reset = 1'b0;
      cyc();

      // Normal run: 10 enabled cycles then core_done.
      en_seen = 0; k = 0; req = 1'b1;
      do begin cyc(); k++; end while (!last_en && k < 20);
      chk("latency", 32'(k), 32'(RST_CYCLES + 2));
      finish_at("normal_bound", 10);
      chk("normal_done", 32'(done), 32'd1);
      chk("normal_count", 32'(cycle_count), 32'd10);
      chk("normal_to", 32'(timeout), 32'd0);
      chk("normal_en", 32'(en_seen), 32'd10);
      cyc(); cyc();
      chk("normal_done_held", 32'(done), 32'd1);
      release_req();
      chk("normal_idle_rst", 32'(core_reset), 32'd1);

      // Watchdog.
      en_seen = 0; req = 1'b1;
      finish_at("wd_bound", -1);
      chk("wd_done", 32'(done), 32'd1);
      chk("wd_to", 32'(timeout), 32'd1);
      chk("wd_count", 32'(cycle_count), 32'(TIMEOUT));
      chk("wd_en", 32'(en_seen), 32'(TIMEOUT));
      release_req();

      // Single-step: three pulses four cycles apart.
      step_mode = 1'b1; req = 1'b1;
      wait_run("ss_wait");
      en_seen = 0;
      for (int p = 0; p < 3; p++) begin
         cyc(); cyc(); cyc();
         step_pulse = 1'b1; cyc(); step_pulse = 1'b0;
      end
      cyc();
      finish_at("ss_bound", 3);
      chk("ss_en", 32'(en_seen), 32'd3);
      chk("ss_count", 32'(cycle_count), 32'd3);
      chk("ss_done", 32'(done), 32'd1);
      step_mode = 1'b0;
      release_req();

      // core_done coincides with the last enabled cycle before the watchdog.
      req = 1'b1;
      finish_at("coin_bound", TIMEOUT - 1);
      chk("coin_to", 32'(timeout), 32'd0);
      chk("coin_count", 32'(cycle_count), 32'(TIMEOUT - 1));
      release_req();

      // core_done during reset hold is ignored.
      req = 1'b1; core_done = 1'b1;
      k = 0;
      while (!m_run && k < 20) begin cyc(); k++; end
      core_done = 1'b0;
      finish_at("hold_bound", 5);
      chk("hold_count", 32'(cycle_count), 32'd5);
      chk("hold_to", 32'(timeout), 32'd0);
      release_req();

      // Reset mid-run after 5 enabled cycles, then a fresh run.
      req = 1'b1;
      wait_run("mid_wait");
      k = 0;
      while (m_count < 5 && k < 20) begin cyc(); k++; end
      reset = 1'b1; cyc(); reset = 1'b0;
      chk("mid_count", 32'(cycle_count), 32'd0);
      chk("mid_core_reset", 32'(core_reset), 32'd1);
      chk("mid_busy", 32'(busy), 32'd0);
      finish_at("mid_rerun", 4);
      chk("mid_rerun_count", 32'(cycle_count), 32'd4);
      release_req();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 8) req = ~req;
         if ($urandom_range(0, 99) < 3) step_mode = ~step_mode;
         step_pulse = ($urandom_range(0, 2) == 0);
         core_done  = ($urandom_range(0, 29) == 0);
         reset      = ($urandom_range(0, 799) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
